// File: rtl/regfile_1w_nr.sv
// regfile_1w_nr: one-write, NRD-read register file with self-clearing init sequence
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             re-zero the whole array (ignored while already clearing)
//   din/wraddr/wren single write port; out-of-range addresses are dropped
//   rdaddr/rd       NRD packed read addresses and per-port enables
//   dout/dout_vld   registered read data (1-cycle latency) and valid strobes
//   init_busy       high while the array is being zeroed
module regfile_1w_nr #(
    parameter int DATA_W = 72,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int NRD    = 4,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [DATA_W-1:0]       din,
    input  logic [ADDR_W-1:0]       wraddr,
    input  logic                    wren,
    input  logic [NRD*ADDR_W-1:0]   rdaddr,
    input  logic [NRD-1:0]          rd,
    output logic [NRD*DATA_W-1:0]   dout,
    output logic [NRD-1:0]          dout_vld,
    output logic                    init_busy
);
    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_ptr, w_ptr_nxt;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [NRD*DATA_W-1:0] r_dout, w_dout_nxt;
    logic [NRD-1:0]        r_vld, w_vld_nxt;
    logic                  w_ready, w_wr_ok;
    logic [ADDR_W-1:0]     w_ra    [NRD];
    logic [DATA_W-1:0]     w_rdata [NRD];

    assign w_ready   = (r_state == ST_READY);
    // clr wins over a same-cycle write, so a dropped write must not be forwarded either
    assign w_wr_ok   = w_ready && wren && !clr && ({1'b0, wraddr} < LP_DEPTH);
    assign init_busy = (r_state == ST_INIT);
    assign dout      = r_dout;
    assign dout_vld  = r_vld;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (r_state == ST_INIT) begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_state_nxt = (r_ptr == LP_LAST) ? ST_READY : ST_INIT;
        end else if (clr) begin
            w_state_nxt = ST_INIT;
            w_ptr_nxt   = '0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NRD; i++) begin : g_rd
            assign w_ra[i]    = rdaddr[i*ADDR_W +: ADDR_W];
            assign w_rdata[i] = ({1'b0, w_ra[i]} >= LP_DEPTH) ? '0 :
                                (BYPASS != 0 && w_wr_ok && w_ra[i] == wraddr) ? din :
                                r_mem[w_ra[i]];
            assign w_dout_nxt[i*DATA_W +: DATA_W] = (w_ready && rd[i]) ? w_rdata[i] :
                                                    r_dout[i*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_vld_nxt = w_ready ? rd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_dout  <= '0;
            r_vld   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_dout  <= w_dout_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    // Array has no reset; the INIT sweep defines its contents
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT)
            r_mem[r_ptr] <= '0;
        else if (w_wr_ok)
            r_mem[wraddr] <= din;
    end
endmodule

// File: tb/tb_regfile_1w_nr.sv
// tb_regfile_1w_nr: directed checks of regfile_1w_nr (default, no-bypass and 200-deep builds)
module tb_regfile_1w_nr;
    localparam int DW = 72;
    localparam int AW = 8;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr = 1'b0;
    logic            wren = 1'b0;
    logic [DW-1:0]   din = '0;
    logic [AW-1:0]   wraddr = '0;
    logic [N*AW-1:0] rdaddr = '0;
    logic [N-1:0]    rd = '0;
    logic [N*DW-1:0] dout_a, dout_b, dout_c;
    logic [N-1:0]    vld_a, vld_b, vld_c;
    logic            busy_a, busy_b, busy_c;
    int              checks = 0;
    int              failures = 0;

    regfile_1w_nr u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wraddr(wraddr), .wren(wren),
        .rdaddr(rdaddr), .rd(rd), .dout(dout_a), .dout_vld(vld_a), .init_busy(busy_a));

    regfile_1w_nr #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wraddr(wraddr), .wren(wren),
        .rdaddr(rdaddr), .rd(rd), .dout(dout_b), .dout_vld(vld_b), .init_busy(busy_b));

    regfile_1w_nr #(.DEPTH(200)) u_d200 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wraddr(wraddr), .wren(wren),
        .rdaddr(rdaddr), .rd(rd), .dout(dout_c), .dout_vld(vld_c), .init_busy(busy_c));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wren = 1'b1; wraddr = a; din = d;
        cyc();
        wren = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) cyc();
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy: got %0b want 1", busy_a); end
        checks++;
        if (dout_a !== '0) begin failures++; $display("FAIL reset_dout: got %0h want 0", dout_a); end
        checks++;
        if (vld_a !== '0) begin failures++; $display("FAIL reset_vld: got %0b want 0", vld_a); end
    endtask

    task automatic test_init_count();
        int na = 0, nc = 0, k = 0;
        rst_n = 1'b1;
        while ((busy_a || busy_c) && k < 1000) begin
            na += int'(busy_a); nc += int'(busy_c); k++;
            cyc();
        end
        checks++;
        if (na != 256) begin failures++; $display("FAIL init_len_256: got %0d want 256", na); end
        checks++;
        if (nc != 200) begin failures++; $display("FAIL init_len_200: got %0d want 200", nc); end
        rdaddr = {8'd0, 8'd255, 8'd128, 8'd0};
        rd = 4'b0111;
        cyc();
        rd = '0;
        checks++;
        if (dout_a[3*DW-1:0] !== '0) begin failures++; $display("FAIL init_zero: got %0h want 0", dout_a[3*DW-1:0]); end
        checks++;
        if (vld_a !== 4'b0111) begin failures++; $display("FAIL init_vld: got %0b want 0111", vld_a); end
    endtask

    task automatic test_write_read_all();
        wr(8'd7, 72'hA5);
        rd = 4'hF;
        rdaddr = {4{8'd7}};
        cyc();
        rd = '0;
        checks++;
        if (dout_a !== {4{72'hA5}}) begin failures++; $display("FAIL all_ports_a5: got %0h want %0h", dout_a, {4{72'hA5}}); end
        checks++;
        if (vld_a !== 4'hF) begin failures++; $display("FAIL all_ports_vld: got %0b want 1111", vld_a); end
        cyc();
        checks++;
        if (vld_a !== 4'h0) begin failures++; $display("FAIL idle_vld: got %0b want 0000", vld_a); end
        checks++;
        if (dout_a !== {4{72'hA5}}) begin failures++; $display("FAIL idle_hold: got %0h want %0h", dout_a, {4{72'hA5}}); end
    endtask

    task automatic test_bypass();
        wr(8'd9, 72'h11);
        wren = 1'b1; wraddr = 8'd9; din = 72'h3C;
        rd = 4'b0100; rdaddr = '0; rdaddr[2*AW +: AW] = 8'd9;
        cyc();
        wren = 1'b0; rd = '0;
        checks++;
        if (dout_a[2*DW +: DW] !== 72'h3C) begin failures++; $display("FAIL bypass_on: got %0h want 3c", dout_a[2*DW +: DW]); end
        checks++;
        if (dout_b[2*DW +: DW] !== 72'h11) begin failures++; $display("FAIL bypass_off: got %0h want 11", dout_b[2*DW +: DW]); end
        rd = 4'b0100;
        cyc();
        rd = '0;
        checks++;
        if (dout_b[2*DW +: DW] !== 72'h3C) begin failures++; $display("FAIL bypass_off_after: got %0h want 3c", dout_b[2*DW +: DW]); end
    endtask

    task automatic test_out_of_range();
        wr(8'd250, 72'h77);
        rdaddr = {8'd0, 8'd50, 8'd7, 8'd250};
        rd = 4'b0111;
        cyc();
        rd = '0;
        checks++;
        if (dout_c[DW-1:0] !== '0) begin failures++; $display("FAIL oor_read: got %0h want 0", dout_c[DW-1:0]); end
        checks++;
        if (vld_c !== 4'b0111) begin failures++; $display("FAIL oor_vld: got %0b want 0111", vld_c); end
        checks++;
        if (dout_c[DW +: DW] !== 72'hA5) begin failures++; $display("FAIL oor_keep7: got %0h want a5", dout_c[DW +: DW]); end
        checks++;
        if (dout_c[2*DW +: DW] !== '0) begin failures++; $display("FAIL oor_keep50: got %0h want 0", dout_c[2*DW +: DW]); end
        checks++;
        if (dout_a[DW-1:0] !== 72'h77) begin failures++; $display("FAIL inrange_250: got %0h want 77", dout_a[DW-1:0]); end
    endtask

    task automatic test_multiport();
        for (int i = 0; i < 4; i++) wr(AW'(20 + i), DW'(256 + i));
        rdaddr = {8'd20, 8'd21, 8'd22, 8'd23};
        rd = 4'hF;
        cyc();
        rd = '0;
        checks++;
        if (dout_a !== {72'h100, 72'h101, 72'h102, 72'h103}) begin
            failures++; $display("FAIL multiport: got %0h want %0h", dout_a, {72'h100, 72'h101, 72'h102, 72'h103});
        end
    endtask

    task automatic test_clr();
        int n = 0, bad = 0;
        wr(8'd3, 72'h55);
        clr = 1'b1; wren = 1'b1; wraddr = 8'd3; din = 72'hFF;
        rd = 4'b0001; rdaddr = {4{8'd3}};
        cyc();
        clr = 1'b0;
        checks++;
        if (dout_a[DW-1:0] !== 72'h55) begin failures++; $display("FAIL clr_read_pre: got %0h want 55", dout_a[DW-1:0]); end
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL clr_busy: got %0b want 1", busy_a); end
        rd = 4'hF;
        while (busy_a && n < 1000) begin
            if (n > 0 && vld_a !== 4'h0) bad++;
            clr = (n == 50);
            n++;
            cyc();
        end
        clr = 1'b0; wren = 1'b0; rd = '0;
        checks++;
        if (n != 256) begin failures++; $display("FAIL clr_init_len: got %0d want 256", n); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL init_rd_ignored: got %0d valid cycles want 0", bad); end
        checks++;
        if (dout_a[DW-1:0] !== 72'h55) begin failures++; $display("FAIL init_dout_hold: got %0h want 55", dout_a[DW-1:0]); end
        rd = 4'b0001;
        cyc();
        rd = '0;
        checks++;
        if (dout_a[DW-1:0] !== '0) begin failures++; $display("FAIL clr_read3: got %0h want 0", dout_a[DW-1:0]); end
    endtask

    task automatic test_reset_mid_init();
        int n = 0;
        wr(8'd7, 72'hA5);
        rd = 4'b0001; rdaddr = {4{8'd7}};
        cyc();
        rd = '0;
        checks++;
        if (dout_a[DW-1:0] !== 72'hA5) begin failures++; $display("FAIL pre_rst_read: got %0h want a5", dout_a[DW-1:0]); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (100) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b1 || dout_a !== '0 || vld_a !== '0) begin
            failures++; $display("FAIL async_reset: got busy=%0b dout=%0h vld=%0b want 1/0/0", busy_a, dout_a, vld_a);
        end
        rst_n = 1'b1;
        while (busy_a && n < 1000) begin
            n++;
            cyc();
        end
        checks++;
        if (n != 256) begin failures++; $display("FAIL restart_len: got %0d want 256", n); end
        rd = 4'b0011; rdaddr = {8'd0, 8'd0, 8'd3, 8'd7};
        cyc();
        rd = '0;
        checks++;
        if (dout_a[2*DW-1:0] !== '0 || vld_a !== 4'b0011) begin
            failures++; $display("FAIL restart_zero: got %0h vld=%0b want 0 vld=0011", dout_a[2*DW-1:0], vld_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init_count();
        test_write_read_all();
        test_bypass();
        test_out_of_range();
        test_multiport();
        test_clr();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
